// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase sequencer with a shared pedestrian WALK phase.
// Phases advance on the 1 Hz TICK enable; pedestrians are served from all-red.
//
// Ports:
//   CLK, RESET (async, active-high), TICK (1-cycle enable), PED_REQ (level)
//   NS_RED/NS_YELLOW/NS_GREEN, EW_RED/EW_YELLOW/EW_GREEN : vehicle lamps
//   WALK : pedestrian lamp, PED_PENDING : latched unserved request
//   REMAIN : ticks left in current phase, PHASE : current state code
module intersection_phase_scheduler #(
    parameter int unsigned GREEN_SEC  = 4,
    parameter int unsigned YELLOW_SEC = 1,
    parameter int unsigned ALLRED_SEC = 1,
    parameter int unsigned WALK_SEC   = 3,
    parameter int unsigned CW         = 3
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          TICK,
    input  logic          PED_REQ,
    output logic          NS_RED,
    output logic          NS_YELLOW,
    output logic          NS_GREEN,
    output logic          EW_RED,
    output logic          EW_YELLOW,
    output logic          EW_GREEN,
    output logic          WALK,
    output logic          PED_PENDING,
    output logic [CW-1:0] REMAIN,
    output logic [2:0]    PHASE
);

    typedef enum logic [2:0] {
        NS_GO    = 3'd0,
        NS_WARN  = 3'd1,
        CLEAR_A  = 3'd2,
        EW_GO    = 3'd3,
        EW_WARN  = 3'd4,
        CLEAR_B  = 3'd5,
        PED_WALK = 3'd6
    } state_t;

    // A zero-length phase would stall REMAIN at 0, so it is stretched to 1.
    localparam logic [CW-1:0] D_GREEN =
        CW'((GREEN_SEC == 0) ? 1 : GREEN_SEC);
    localparam logic [CW-1:0] D_YELLOW =
        CW'((YELLOW_SEC == 0) ? 1 : YELLOW_SEC);
    localparam logic [CW-1:0] D_ALLRED =
        CW'((ALLRED_SEC == 0) ? 1 : ALLRED_SEC);
    localparam logic [CW-1:0] D_WALK =
        CW'((WALK_SEC == 0) ? 1 : WALK_SEC);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [2:0]    phase_q;
    logic [CW-1:0] remain_q;
    logic          ped_q;
    logic          resume_ew_q;

    state_t        nxt;
    logic [CW-1:0] nxt_dur;
    logic          nxt_resume_ew;
    logic          phase_end;

    always_comb begin
        nxt           = NS_GO;
        nxt_resume_ew = resume_ew_q;
        case (phase_q)
            NS_GO:    nxt = NS_WARN;
            NS_WARN:  nxt = CLEAR_A;
            CLEAR_A: begin
                nxt_resume_ew = 1'b1;
                nxt = ped_q ? PED_WALK : EW_GO;
            end
            EW_GO:    nxt = EW_WARN;
            EW_WARN:  nxt = CLEAR_B;
            CLEAR_B: begin
                nxt_resume_ew = 1'b0;
                nxt = ped_q ? PED_WALK : NS_GO;
            end
            PED_WALK: nxt = resume_ew_q ? EW_GO : NS_GO;
            default:  nxt = CLEAR_A;
        endcase
    end

    always_comb begin
        nxt_dur = D_ALLRED;
        case (nxt)
            NS_GO, EW_GO:     nxt_dur = D_GREEN;
            NS_WARN, EW_WARN: nxt_dur = D_YELLOW;
            PED_WALK:         nxt_dur = D_WALK;
            default:          nxt_dur = D_ALLRED;
        endcase
    end

    // Code 7 recovers on the next edge without waiting for TICK.
    assign phase_end = (phase_q == 3'd7) ||
                       (TICK && (remain_q <= ONE));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase_q     <= NS_GO;
            remain_q    <= D_GREEN;
            ped_q       <= 1'b0;
            resume_ew_q <= 1'b1;
        end else begin
            if (phase_end) begin
                phase_q     <= nxt;
                remain_q    <= nxt_dur;
                resume_ew_q <= nxt_resume_ew;
            end else if (TICK) begin
                remain_q <= remain_q - ONE;
            end
            // Granting the walk wins over a same-cycle button press.
            if (phase_end && (nxt == PED_WALK)) begin
                ped_q <= 1'b0;
            end else if (PED_REQ && (phase_q != PED_WALK)) begin
                ped_q <= 1'b1;
            end
        end
    end

    always_comb begin
        NS_RED    = 1'b1;
        NS_YELLOW = 1'b0;
        NS_GREEN  = 1'b0;
        EW_RED    = 1'b1;
        EW_YELLOW = 1'b0;
        EW_GREEN  = 1'b0;
        WALK      = 1'b0;
        case (phase_q)
            NS_GO: begin
                NS_RED   = 1'b0;
                NS_GREEN = 1'b1;
            end
            NS_WARN: begin
                NS_RED    = 1'b0;
                NS_YELLOW = 1'b1;
            end
            EW_GO: begin
                EW_RED   = 1'b0;
                EW_GREEN = 1'b1;
            end
            EW_WARN: begin
                EW_RED    = 1'b0;
                EW_YELLOW = 1'b1;
            end
            PED_WALK: WALK = 1'b1;
            default: ;
        endcase
    end

    assign PED_PENDING = ped_q;
    assign REMAIN      = remain_q;
    assign PHASE       = phase_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench for intersection_phase_scheduler.
// Vector table, directed corner cases and random traffic against a model.
module tb_intersection_phase_scheduler;

    localparam int G  = 4;
    localparam int Y  = 1;
    localparam int AR = 1;
    localparam int W  = 3;
    localparam int CW = 3;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          TICK;
    logic          PED_REQ;
    logic          NS_RED, NS_YELLOW, NS_GREEN;
    logic          EW_RED, EW_YELLOW, EW_GREEN;
    logic          WALK, PED_PENDING;
    logic [CW-1:0] REMAIN;
    logic [2:0]    PHASE;

    intersection_phase_scheduler #(
        .GREEN_SEC(G), .YELLOW_SEC(Y), .ALLRED_SEC(AR),
        .WALK_SEC(W), .CW(CW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .TICK(TICK), .PED_REQ(PED_REQ),
        .NS_RED(NS_RED), .NS_YELLOW(NS_YELLOW), .NS_GREEN(NS_GREEN),
        .EW_RED(EW_RED), .EW_YELLOW(EW_YELLOW), .EW_GREEN(EW_GREEN),
        .WALK(WALK), .PED_PENDING(PED_PENDING),
        .REMAIN(REMAIN), .PHASE(PHASE)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference: phase number, seconds left, request latch, resume road.
    int m_ph;
    int m_rem;
    bit m_ped;
    bit m_res_ew;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d @%0t",
                      name, got, exp, $time);
    endtask

    function automatic int dur(input int p);
        int d;
        case (p)
            0, 3:    d = G;
            1, 4:    d = Y;
            6:       d = W;
            default: d = AR;
        endcase
        return (d == 0) ? 1 : d;
    endfunction

    // {NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G, WALK} for each phase.
    function automatic int lamps_for(input int p);
        case (p)
            0:       return 7'b0011000;
            1:       return 7'b0101000;
            3:       return 7'b1000010;
            4:       return 7'b1000100;
            6:       return 7'b1001001;
            default: return 7'b1001000;
        endcase
    endfunction

    function automatic int succ(input int p);
        case (p)
            0:       return 1;
            1:       return 2;
            2:       return m_ped ? 6 : 3;
            3:       return 4;
            4:       return 5;
            5:       return m_ped ? 6 : 0;
            6:       return m_res_ew ? 3 : 0;
            default: return 2;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = 0; m_rem = dur(0); m_ped = 0; m_res_ew = 1;
    endtask

    task automatic model_step(input bit t, input bit r);
        int np;
        bit ends;
        np = m_ph;
        ends = (m_ph == 7) || (t && m_rem == 1);
        if (ends) begin
            np = succ(m_ph);
            if (m_ph == 2) m_res_ew = 1;
            if (m_ph == 5) m_res_ew = 0;
            m_rem = dur(np);
        end else if (t) begin
            m_rem = m_rem - 1;
        end
        if (np == 6 && m_ph != 6) m_ped = 0;
        else if (r && m_ph != 6) m_ped = 1;
        m_ph = np;
    endtask

    task automatic compare_model();
        int lamps;
        lamps = {NS_RED, NS_YELLOW, NS_GREEN,
                 EW_RED, EW_YELLOW, EW_GREEN, WALK};
        chk("phase", int'(PHASE), m_ph);
        chk("remain", int'(REMAIN), m_rem);
        chk("ped_pending", int'(PED_PENDING), int'(m_ped));
        chk("lamps", lamps, lamps_for(m_ph));
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input bit t, input bit r);
        TICK = t;
        PED_REQ = r;
        @(posedge CLK);
        model_step(t, r);
        #1 compare_model();
        @(negedge CLK);
    endtask

    task automatic run_until(input int p);
        int n;
        n = 0;
        while (m_ph != p && n < 200) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        chk("reach_phase", int'(PHASE), p);
    endtask

    typedef struct {
        bit tick;
        bit req;
        int ph;
        int rem;
        bit ped;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{1, 0, 0, 3, 0};
        vt[1] = '{0, 1, 0, 3, 1};
        vt[2] = '{1, 0, 0, 2, 1};
        vt[3] = '{1, 0, 0, 1, 1};
        vt[4] = '{1, 0, 1, 1, 1};
        vt[5] = '{1, 0, 2, 1, 1};
        vt[6] = '{1, 0, 6, 3, 0};
        vt[7] = '{1, 1, 6, 2, 0};
        vt[8] = '{1, 1, 6, 1, 0};
        vt[9] = '{1, 0, 3, 4, 0};

        RESET = 1'b1;
        TICK = 1'b0;
        PED_REQ = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        compare_model();
        RESET = 1'b0;
        @(negedge CLK);

        // Pedestrian served from CLEAR_A, request held during walk.
        for (int i = 0; i < 10; i++) begin
            cycle(vt[i].tick, vt[i].req);
            chk("vec_phase", int'(PHASE), vt[i].ph);
            chk("vec_remain", int'(REMAIN), vt[i].rem);
            chk("vec_ped", int'(PED_PENDING), int'(vt[i].ped));
        end

        // Request on the CLEAR_A expiry edge goes to the next all-red.
        run_until(2);
        cycle(1'b1, 1'b1);
        chk("edge_req_phase", int'(PHASE), 3);
        chk("edge_req_ped", int'(PED_PENDING), 1);
        run_until(5);
        cycle(1'b1, 1'b0);
        chk("walk_after_b", int'(PHASE), 6);
        for (int i = 0; i < W; i++) cycle(1'b1, 1'b0);
        chk("ns_after_walk", int'(PHASE), 0);

        // Idle rotation with a TICK every fourth clock.
        for (int i = 0; i < 96; i++) cycle(i % 4 == 3, 1'b0);

        // Long TICK gap holds state.
        run_until(3);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0);
        chk("gap_phase", int'(PHASE), 3);
        chk("gap_remain", int'(REMAIN), 2);
        cycle(1'b1, 1'b0);
        chk("gap_resume", int'(REMAIN), 1);

        // Asynchronous reset in the middle of a walk.
        cycle(1'b0, 1'b1);
        run_until(6);
        cycle(1'b1, 1'b0);
        #2 RESET = 1'b1;
        #1;
        model_reset();
        chk("ar_phase", int'(PHASE), 0);
        chk("ar_remain", int'(REMAIN), G);
        chk("ar_ped", int'(PED_PENDING), 0);
        chk("ar_ns_green", int'(NS_GREEN), 1);
        chk("ar_ew_red", int'(EW_RED), 1);
        chk("ar_walk", int'(WALK), 0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        // Illegal code 7 recovers to CLEAR_A without a TICK.
        force dut.phase_q = 3'd7;
        #1 release dut.phase_q;
        chk("illegal_lamps", {NS_RED, EW_RED, WALK}, 3'b110);
        m_ph = 7;
        cycle(1'b0, 1'b0);
        chk("illegal_phase", int'(PHASE), 2);
        chk("illegal_remain", int'(REMAIN), AR);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
